display_page_scheduler: RTL and testbench
=========================================

# display_page_scheduler

Sequences the 7-segment display between its two pages, water tank level and irrigation condition, by driving the select input of `mux_2_1`. Each page dwells for a fixed number of clock cycles, and a blanking gap separates page switches so the decoder never shows a mixed glyph. A tank alarm forces the water-level page, and an operator hold freezes the current page. The block sits between the sensor/control logic and the display mux.

## Interface
- `DWELL_CYCLES`, default 50_000_000: cycles each page is shown (1 s at 50 MHz); must be ≥ 1.
- `BLANK_CYCLES`, default 2_500_000: cycles of blanking between pages; 0 means no blanking.
- `CNT_W`, default $clog2(max(DWELL_CYCLES, BLANK_CYCLES, 2)): dwell counter width.
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  scheduler run; low parks the display blanked.
- `hold_i`  in  1  freeze the current page while high.
- `alarm_i`  in  1  tank critical; force the water page.
- `selector_o`  out  1  to `mux_2_1` select; 0 = water level, 1 = irrigation.
- `blank_o`  out  1  high = all segments off.
- `page_change_o`  out  1  one-cycle pulse on entering a SHOW state.

## Operation
- Moore FSM with five states: IDLE, SHOW_WATER, BLANK_TO_IRR, SHOW_IRR, BLANK_TO_WATER.
- Output encoding:
  - IDLE: `selector_o`=0, `blank_o`=1.
  - SHOW_WATER: 0/0.
  - BLANK_TO_IRR: 1/1. The selector switches at blank start so the mux settles under blanking.
  - SHOW_IRR: 1/0.
  - BLANK_TO_WATER: 0/1.
- Dwell counter clears to 0 on every state entry and increments each cycle in SHOW/BLANK states.
- A SHOW state exits when count == DWELL_CYCLES−1 and hold is inactive. It enters the BLANK state, or the next SHOW state directly if BLANK_CYCLES = 0.
- A BLANK state exits when count == BLANK_CYCLES−1.
- Priority per cycle: `reset_i` > `!enable_i` > `alarm_i` > `hold_i` > counter expiry.
  - `!enable_i`: next state IDLE from any state.
  - `alarm_i` (enabled): next state SHOW_WATER from any state, including mid-blank, with the counter cleared. While alarm stays high, the state remains SHOW_WATER and the counter is held at 0. When alarm falls, a full dwell starts.
  - `hold_i`: in SHOW states, the counter freezes at its value and no exit occurs. Counting resumes from the frozen value when hold falls. In BLANK states hold is ignored and the blank completes. IDLE → SHOW_WATER is not blocked by hold.
- From IDLE with `enable_i`=1: next state SHOW_WATER. Water is always the first page after enable.
- `page_change_o`=1 for exactly the first cycle of any SHOW state entered from a different state. Remaining in SHOW_WATER under alarm does not pulse.

## Timing
- Reset values: state IDLE, counter 0, `selector_o`=0, `blank_o`=1, `page_change_o`=0.
- All outputs are registered. An input sampled at edge k affects outputs after edge k, giving one cycle of latency.
- Steady-state period with enable=1, hold=0, alarm=0: 2·(DWELL_CYCLES+BLANK_CYCLES) cycles.
- Reset mid-operation is honoured on the next edge regardless of state or counter value.
- Enable drop during a BLANK state: IDLE next cycle; the blank is not completed.
- Counter must not overflow: parameters are checked at elaboration so both fit in CNT_W.

## Structure
- Package `display_sched_pkg`:
  - state enum `sched_state_t`;
  - constants `PAGE_WATER`=1'b0 and `PAGE_IRR`=1'b1;
  - elaboration-check helper for the parameters.
- One sub-module, `dwell_counter`: CNT_W up-counter with synchronous clear, hold, and terminal compare against a runtime limit. It outputs `done`.
- Top level holds the FSM, output registers and pulse generation.

## Test plan
(All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=2.)
- Reset, then `enable_i`=1 at cycle 0:
  - cycles 1–4 `selector_o`=0, `blank_o`=0, with `page_change_o`=1 at cycle 1;
  - cycles 5–6 1/1;
  - cycles 7–10 1/0, with pulse at 7;
  - cycles 11–12 0/1;
  - cycle 13 SHOW_WATER again (12-cycle period).
- `hold_i` high for 5 cycles starting at the 2nd SHOW_IRR cycle: SHOW_IRR lasts 9 cycles total, with no blank during the hold.
- `alarm_i` pulse during BLANK_TO_IRR: next cycle 0/0 with `page_change_o`=1. After alarm falls, the water page lasts exactly 4 cycles.
- `alarm_i` and `hold_i` both high in SHOW_IRR: alarm wins, giving SHOW_WATER next cycle.
- `enable_i` drop mid-SHOW_IRR, then `reset_i` pulse: IDLE outputs 0/1/0 both times. Re-enable restarts at SHOW_WATER.
- Parameter variant BLANK_CYCLES=0: `blank_o` never rises after enable; `selector_o` toggles every 4 cycles with a pulse at each toggle.

Source files
------------

// File: rtl/display_page_scheduler_pkg.sv
// Shared types, page encodings and parameter sanity helpers for the
// display page scheduler.
package display_sched_pkg;

   // Scheduler FSM states.
   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_SHOW_WATER     = 3'd1,
      ST_BLANK_TO_IRR   = 3'd2,
      ST_SHOW_IRR       = 3'd3,
      ST_BLANK_TO_WATER = 3'd4
   } sched_state_t;

   // Select values presented to the display mux.
   localparam logic PAGE_WATER = 1'b0;
   localparam logic PAGE_IRR   = 1'b1;

   // Largest of three values, used to size the dwell counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

   // True when both cycle counts can be reached by a cnt_w-bit counter
   // that runs from 0 up to (cycles - 1), and the dwell is non-zero.
   function automatic bit params_ok(input longint unsigned dwell,
                                    input longint unsigned blank,
                                    input longint unsigned cnt_w);
      return (cnt_w >= 64'd1) && (cnt_w <= 64'd32) &&
             (dwell >= 64'd1) &&
             (dwell <= (64'd1 << cnt_w)) &&
             (blank <= (64'd1 << cnt_w));
   endfunction

endpackage

// File: rtl/display_page_scheduler_dwell_counter.sv
// Up-counter with synchronous clear and hold; done flags the last cycle
// of the interval selected by the runtime terminal value.
module dwell_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             hold_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] last_i,
   output logic             done_o
);

   logic [CNT_W-1:0] r_count;

   // Count register: clear wins over hold, hold wins over increment.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_count <= '0;
      end else if (clear_i) begin
         r_count <= '0;
      end else if (hold_i) begin
         r_count <= r_count;
      end else if (en_i) begin
         r_count <= r_count + CNT_W'(1'b1);
      end else begin
         r_count <= r_count;
      end
   end

   assign done_o = (r_count == last_i);

endmodule

// File: rtl/display_page_scheduler.sv
// Alternates the 7-segment display between the water-level and irrigation
// pages with blanking gaps; alarm forces the water page, hold freezes a page.
module display_page_scheduler
   import display_sched_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 50_000_000,
   parameter int unsigned BLANK_CYCLES = 2_500_000,
   parameter int unsigned CNT_W        = $clog2(max3(DWELL_CYCLES, BLANK_CYCLES, 32'd2))
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic enable_i,
   input  logic hold_i,
   input  logic alarm_i,
   output logic selector_o,
   output logic blank_o,
   output logic page_change_o
);

   generate
      if (!params_ok(64'(DWELL_CYCLES), 64'(BLANK_CYCLES), 64'(CNT_W))) begin : g_param_check
         $error("display_page_scheduler: DWELL_CYCLES/BLANK_CYCLES do not fit CNT_W or dwell is zero");
      end
   endgenerate

   // Terminal counts; the blank terminal is unused when blanking is disabled.
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES == 32'd0) ? '0 : CNT_W'(BLANK_CYCLES - 32'd1);
   localparam logic             NO_BLANK   = (BLANK_CYCLES == 32'd0);

   sched_state_t     r_state;
   sched_state_t     w_next_state;
   logic             r_selector;
   logic             r_blank;
   logic             r_page_change;
   logic             w_clear;
   logic             w_done;
   logic             w_in_show;
   logic             w_in_blank;
   logic [CNT_W-1:0] w_last;
   logic             w_sel_next;
   logic             w_blank_next;
   logic             w_show_next;

   assign w_in_show  = (r_state == ST_SHOW_WATER) || (r_state == ST_SHOW_IRR);
   assign w_in_blank = (r_state == ST_BLANK_TO_IRR) || (r_state == ST_BLANK_TO_WATER);
   assign w_last     = w_in_blank ? BLANK_LAST : DWELL_LAST;

   dwell_counter #(
      .CNT_W (CNT_W)
   ) u_dwell_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (w_clear),
      .hold_i  (hold_i && w_in_show),
      .en_i    (r_state != ST_IDLE),
      .last_i  (w_last),
      .done_o  (w_done)
   );

   // Next state and counter clear: disable, then alarm, then per-state expiry.
   always_comb begin
      w_next_state = r_state;
      w_clear      = 1'b0;
      if (!enable_i) begin
         w_next_state = ST_IDLE;
         w_clear      = 1'b1;
      end else if (alarm_i) begin
         w_next_state = ST_SHOW_WATER;
         w_clear      = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_next_state = ST_SHOW_WATER;
               w_clear      = 1'b1;
            end
            ST_SHOW_WATER: begin
               if (!hold_i && w_done) begin
                  w_next_state = NO_BLANK ? ST_SHOW_IRR : ST_BLANK_TO_IRR;
                  w_clear      = 1'b1;
               end else begin
                  w_next_state = r_state;
                  w_clear      = 1'b0;
               end
            end
            ST_BLANK_TO_IRR: begin
               if (w_done) begin
                  w_next_state = ST_SHOW_IRR;
                  w_clear      = 1'b1;
               end else begin
                  w_next_state = r_state;
                  w_clear      = 1'b0;
               end
            end
            ST_SHOW_IRR: begin
               if (!hold_i && w_done) begin
                  w_next_state = NO_BLANK ? ST_SHOW_WATER : ST_BLANK_TO_WATER;
                  w_clear      = 1'b1;
               end else begin
                  w_next_state = r_state;
                  w_clear      = 1'b0;
               end
            end
            ST_BLANK_TO_WATER: begin
               if (w_done) begin
                  w_next_state = ST_SHOW_WATER;
                  w_clear      = 1'b1;
               end else begin
                  w_next_state = r_state;
                  w_clear      = 1'b0;
               end
            end
            default: begin
               w_next_state = ST_IDLE;
               w_clear      = 1'b1;
            end
         endcase
      end
   end

   // Output decode of the upcoming state; the selector flips at blank start.
   always_comb begin
      w_sel_next   = PAGE_WATER;
      w_blank_next = 1'b1;
      w_show_next  = 1'b0;
      case (w_next_state)
         ST_IDLE: begin
            w_sel_next   = PAGE_WATER;
            w_blank_next = 1'b1;
            w_show_next  = 1'b0;
         end
         ST_SHOW_WATER: begin
            w_sel_next   = PAGE_WATER;
            w_blank_next = 1'b0;
            w_show_next  = 1'b1;
         end
         ST_BLANK_TO_IRR: begin
            w_sel_next   = PAGE_IRR;
            w_blank_next = 1'b1;
            w_show_next  = 1'b0;
         end
         ST_SHOW_IRR: begin
            w_sel_next   = PAGE_IRR;
            w_blank_next = 1'b0;
            w_show_next  = 1'b1;
         end
         ST_BLANK_TO_WATER: begin
            w_sel_next   = PAGE_WATER;
            w_blank_next = 1'b1;
            w_show_next  = 1'b0;
         end
         default: begin
            w_sel_next   = PAGE_WATER;
            w_blank_next = 1'b1;
            w_show_next  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; the pulse marks entry into a SHOW state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state       <= ST_IDLE;
         r_selector    <= PAGE_WATER;
         r_blank       <= 1'b1;
         r_page_change <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_selector    <= w_sel_next;
         r_blank       <= w_blank_next;
         r_page_change <= w_show_next && (w_next_state != r_state);
      end
   end

   assign selector_o    = r_selector;
   assign blank_o       = r_blank;
   assign page_change_o = r_page_change;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Scoreboard bench: directed steps push hand-computed expected outputs,
// a monitor pops and compares one entry per clock after each rising edge.
module tb_display_page_scheduler;

   typedef struct {
      logic  sel;
      logic  blank;
      logic  pc;
      string name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a, rst_b, en, hold, alarm;
   logic sel_a, blank_a, pc_a;
   logic sel_b, blank_b, pc_b;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   target = 0;

   always #5 clk = ~clk;

   display_page_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) u_dut_a (
      .clk_i(clk), .reset_i(rst_a), .enable_i(en), .hold_i(hold), .alarm_i(alarm),
      .selector_o(sel_a), .blank_o(blank_a), .page_change_o(pc_a)
   );

   display_page_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_dut_b (
      .clk_i(clk), .reset_i(rst_b), .enable_i(en), .hold_i(hold), .alarm_i(alarm),
      .selector_o(sel_b), .blank_o(blank_b), .page_change_o(pc_b)
   );

   task automatic check(input string name, input string field, input logic act, input logic req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s: got %b, expected %b (t=%0t)", name, field, act, req, $time);
      end
   endtask

   // Monitor: one expected entry per cycle, sampled 1 time unit after the edge.
   always @(posedge clk) begin
      #1;
      if (q_a.size() > 0) begin
         e_a = q_a.pop_front();
         check(e_a.name, "selector", sel_a, e_a.sel);
         check(e_a.name, "blank", blank_a, e_a.blank);
         check(e_a.name, "page_change", pc_a, e_a.pc);
      end
      if (q_b.size() > 0) begin
         e_b = q_b.pop_front();
         check(e_b.name, "selector", sel_b, e_b.sel);
         check(e_b.name, "blank", blank_b, e_b.blank);
         check(e_b.name, "page_change", pc_b, e_b.pc);
      end
   end

   // Drive inputs for the next edge and record what the outputs must be after it.
   task automatic step(input logic r, input logic e, input logic h, input logic a,
                       input logic s, input logic b, input logic p, input string name);
      exp_t x;
      @(negedge clk);
      if (target == 0) rst_a = r;
      else rst_b = r;
      en    = e;
      hold  = h;
      alarm = a;
      x.sel   = s;
      x.blank = b;
      x.pc    = p;
      x.name  = name;
      if (target == 0) q_a.push_back(x);
      else q_b.push_back(x);
   endtask

   task automatic run(input int n, input logic r, input logic e, input logic h, input logic a,
                      input logic s, input logic b, input logic p_first, input string name);
      for (int i = 0; i < n; i++) begin
         step(r, e, h, a, s, b, (i == 0) ? p_first : 1'b0, name);
      end
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      en    = 1'b0;
      hold  = 1'b0;
      alarm = 1'b0;

      // Instance A: DWELL=4, BLANK=2. Comments give output cycle numbers.
      target = 0;
      run(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "water1");           // 1-4
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "blank_irr1");       // 5-6
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "irr1");             // 7-10
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "blank_wat1");       // 11-12
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "water2");           // 13-16
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "blank_irr2");       // 17-18
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "irr_prehold");      // 19-20
      run(5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "irr_hold");         // 21-25
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "irr_posthold");     // 26-27
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "blank_wat2");       // 28-29
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "water3");           // 30-33
      run(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "blank_irr3");       // 34
      run(1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "alarm_in_blank");   // 35
      run(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "water_post_alarm");  // 36-38
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "blank_irr4");       // 39-40
      run(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "irr4");             // 41
      run(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "alarm_over_hold");  // 42
      run(2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "alarm_held");       // 43-44
      run(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "water_post_alarm2"); // 45-47
      run(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "blank_irr5");       // 48
      run(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "blank_hold_ignored"); // 49
      run(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "irr_after_blank_hold"); // 50
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "irr5");             // 51-52
      run(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "enable_drop");      // 53-54
      run(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reenable");         // 55-56
      run(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_mid");        // 57
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "water_post_reset");  // 58-61
      run(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "blank_irr6");       // 62
      run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "enable_drop_blank"); // 63
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "disabled_alarm");   // 64
      run(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "idle_exit_hold");   // 65

      // Instance B: DWELL=4, BLANK=0 -- pages alternate with no blanking.
      target = 1;
      run(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b_reset");
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b_water1");
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "b_irr1");
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b_water2");
      run(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "b_irr2");

      repeat (3) @(negedge clk);
      n_cmp++;
      if ((q_a.size() != 0) || (q_b.size() != 0)) begin
         n_bad++;
         $display("FAIL drain: %0d/%0d expected entries left, required 0/0", q_a.size(), q_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
